// File: rtl/retirement_rmt_walker_if.sv
// Commit/recovery bundle for the retirement RMT walker: commit slots in, free-list
// releases out, recovery handshake and speculative-RMT write beats out.
interface retirement_rmt_walker_if #(
  parameter int LREG_NUM     = 32,
  parameter int PREG_BITS    = 7,
  parameter int COMMIT_WIDTH = 2,
  parameter int RENAME_WIDTH = 2
);
  localparam int LB = $clog2(LREG_NUM);

  logic [COMMIT_WIDTH-1:0]                commit_valid;
  logic [COMMIT_WIDTH-1:0]                commit_write_reg;
  logic [COMMIT_WIDTH-1:0][LB-1:0]        commit_log_dst;
  logic [COMMIT_WIDTH-1:0][PREG_BITS-1:0] commit_phy_dst;
  logic [COMMIT_WIDTH-1:0]                release_valid;
  logic [COMMIT_WIDTH-1:0][PREG_BITS-1:0] release_phy;
  logic                                   recovery_start;
  logic [RENAME_WIDTH-1:0]                rmt_wr_en;
  logic [RENAME_WIDTH-1:0][LB-1:0]        rmt_wr_log;
  logic [RENAME_WIDTH-1:0][PREG_BITS-1:0] rmt_wr_phy;
  logic                                   recovery_busy;
  logic                                   recovery_done;

  modport master (
    output commit_valid, commit_write_reg, commit_log_dst, commit_phy_dst, recovery_start,
    input  release_valid, release_phy, rmt_wr_en, rmt_wr_log, rmt_wr_phy,
           recovery_busy, recovery_done
  );

  modport slave (
    input  commit_valid, commit_write_reg, commit_log_dst, commit_phy_dst, recovery_start,
    output release_valid, release_phy, rmt_wr_en, rmt_wr_log, rmt_wr_phy,
           recovery_busy, recovery_done
  );
endinterface

// File: rtl/retirement_rmt_walker.sv
// Retirement RMT: committed logical->physical map, free-list release of overwritten
// physical registers, and a recovery walk that copies the map into the speculative RMT.

// One speculative-RMT write lane: entry idx+LANE of the committed map.
module rmt_walk_lane #(
  parameter int LANE      = 0,
  parameter int LREG_NUM  = 32,
  parameter int PREG_BITS = 7,
  parameter int LB        = 5
) (
  input  logic                                active,
  input  logic [LB-1:0]                       idx,
  input  logic [LREG_NUM-1:0][PREG_BITS-1:0]  map,
  output logic                                wrEn,
  output logic [LB-1:0]                       wrLog,
  output logic [PREG_BITS-1:0]                wrPhy
);
  logic [LB-1:0] logIdx;

  assign logIdx = idx + LB'(LANE);
  assign wrEn   = active;
  assign wrLog  = active ? logIdx : '0;
  assign wrPhy  = active ? map[logIdx] : '0;
endmodule

module retirement_rmt_walker #(
  parameter int LREG_NUM     = 32,
  parameter int PREG_BITS    = 7,
  parameter int COMMIT_WIDTH = 2,
  parameter int RENAME_WIDTH = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  retirement_rmt_walker_if.slave bus
);
  localparam int LB = $clog2(LREG_NUM);
  localparam int CW = COMMIT_WIDTH;
  localparam int RW = RENAME_WIDTH;
  localparam logic [LB-1:0] LAST_IDX = LB'(LREG_NUM - RW);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] COPY = 1'b1;

  logic [LREG_NUM-1:0][PREG_BITS-1:0] map;
  logic [CW-1:0]                      eff;
  logic [CW-1:0][PREG_BITS-1:0]       prev;
  logic [CW-1:0]                      relValid;
  logic [CW-1:0][PREG_BITS-1:0]       relPhy;

  logic [0:0]    state;
  logic [LB-1:0] idx;
  logic          done;

  logic [RW-1:0]                wrEn;
  logic [RW-1:0][LB-1:0]        wrLog;
  logic [RW-1:0][PREG_BITS-1:0] wrPhy;

  assign eff = bus.commit_valid & bus.commit_write_reg;

  // Previous mapping per slot: an older same-cycle slot writing the same logical
  // register supersedes the map; the loop runs oldest->youngest so the youngest wins.
  for (genvar s = 0; s < CW; s++) begin : g_slot
    always_comb begin
      prev[s] = map[bus.commit_log_dst[s]];
      for (int j = 0; j < s; j++)
        if (eff[j] && bus.commit_log_dst[j] == bus.commit_log_dst[s])
          prev[s] = bus.commit_phy_dst[j];
    end
  end

  // Map update; later iterations overwrite earlier ones, so the youngest slot wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LREG_NUM; i++) map[i] <= PREG_BITS'(i);
    end else begin
      for (int i = 0; i < CW; i++)
        if (eff[i]) map[bus.commit_log_dst[i]] <= bus.commit_phy_dst[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      relValid <= '0;
      relPhy   <= '0;
    end else begin
      relValid <= eff;
      for (int i = 0; i < CW; i++) relPhy[i] <= eff[i] ? prev[i] : '0;
    end
  end

  // A start during COPY restarts from entry 0 and suppresses the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.recovery_start) begin
        state <= COPY;
        idx   <= '0;
      end else if (state == COPY) begin
        if (idx == LAST_IDX) begin
          state <= IDLE;
          idx   <= '0;
          done  <= 1'b1;
        end else begin
          idx <= idx + LB'(RW);
        end
      end
    end
  end

  rmt_walk_lane #(.LANE(0), .LREG_NUM(LREG_NUM), .PREG_BITS(PREG_BITS), .LB(LB)) u_lane0 (
    .active(state == COPY), .idx(idx), .map(map),
    .wrEn(wrEn[0]), .wrLog(wrLog[0]), .wrPhy(wrPhy[0])
  );

  for (genvar k = 1; k < RW; k++) begin : g_lane
    rmt_walk_lane #(.LANE(k), .LREG_NUM(LREG_NUM), .PREG_BITS(PREG_BITS), .LB(LB)) u_lane (
      .active(state == COPY), .idx(idx), .map(map),
      .wrEn(wrEn[k]), .wrLog(wrLog[k]), .wrPhy(wrPhy[k])
    );
  end

  assign bus.release_valid = relValid;
  assign bus.release_phy   = relPhy;
  assign bus.rmt_wr_en     = wrEn;
  assign bus.rmt_wr_log    = wrLog;
  assign bus.rmt_wr_phy    = wrPhy;
  assign bus.recovery_busy = (state == COPY);
  assign bus.recovery_done = done;
endmodule

// File: tb/tb_retirement_rmt_walker.sv
// Directed bench for retirement_rmt_walker: commit releases, same-cycle bypass,
// recovery walk timing, restart and reset abort, checked against hand-written expectations.
module tb_retirement_rmt_walker;
  localparam int LREG_NUM = 32;
  localparam int PB       = 7;
  localparam int CW       = 2;
  localparam int RW       = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nAsserts = 0;
  int   nFails = 0;
  int   expMap [LREG_NUM];

  retirement_rmt_walker_if #(.LREG_NUM(LREG_NUM), .PREG_BITS(PB), .COMMIT_WIDTH(CW),
                             .RENAME_WIDTH(RW)) bus ();

  retirement_rmt_walker #(.LREG_NUM(LREG_NUM), .PREG_BITS(PB), .COMMIT_WIDTH(CW),
                          .RENAME_WIDTH(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearCommit();
    bus.commit_valid     = '0;
    bus.commit_write_reg = '0;
    bus.commit_log_dst   = '0;
    bus.commit_phy_dst   = '0;
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_busy"}, int'(bus.recovery_busy), 0);
    chk({tag, "_en"},   int'(bus.rmt_wr_en), 0);
    chk({tag, "_log"},  int'(bus.rmt_wr_log), 0);
  endtask

  // Checks n consecutive beats starting at entry 0, ticking after each.
  task automatic checkBeats(input string tag, input int n);
    for (int b = 0; b < n; b++) begin
      chk({tag, "_busy"}, int'(bus.recovery_busy), 1);
      chk({tag, "_done"}, int'(bus.recovery_done), 0);
      chk({tag, "_en"},   int'(bus.rmt_wr_en), 3);
      for (int k = 0; k < RW; k++) begin
        chk($sformatf("%s_b%0d_l%0d_log", tag, b, k), int'(bus.rmt_wr_log[k]), 2*b + k);
        chk($sformatf("%s_b%0d_l%0d_phy", tag, b, k), int'(bus.rmt_wr_phy[k]), expMap[2*b + k]);
      end
      tick();
    end
  endtask

  task automatic startWalk();
    bus.recovery_start = 1'b1;
    tick();
    bus.recovery_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < LREG_NUM; i++) expMap[i] = i;
    clearCommit();
    bus.recovery_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chkIdle("rst");
    chk("rst_done", int'(bus.recovery_done), 0);
    chk("rst_relv", int'(bus.release_valid), 0);

    // 1: identity walk, 16 beats, done on cycle 17
    startWalk();
    checkBeats("walk1", 16);
    chk("walk1_done", int'(bus.recovery_done), 1);
    chkIdle("walk1_after");
    tick();
    chk("walk1_done_pulse", int'(bus.recovery_done), 0);

    // 2: single commit log5->p40 releases p5
    bus.commit_valid = 2'b01; bus.commit_write_reg = 2'b01;
    bus.commit_log_dst[0] = 5'd5; bus.commit_phy_dst[0] = 7'd40;
    tick();
    clearCommit();
    expMap[5] = 40;
    chk("c1_relv",  int'(bus.release_valid), 1);
    chk("c1_phy0",  int'(bus.release_phy[0]), 5);
    chk("c1_phy1",  int'(bus.release_phy[1]), 0);
    tick();
    chk("c1_relv_clr", int'(bus.release_valid), 0);

    // 3: both slots to log7 -> releases 7 then 50, map[7]=51
    bus.commit_valid = 2'b11; bus.commit_write_reg = 2'b11;
    bus.commit_log_dst[0] = 5'd7; bus.commit_phy_dst[0] = 7'd50;
    bus.commit_log_dst[1] = 5'd7; bus.commit_phy_dst[1] = 7'd51;
    tick();
    expMap[7] = 51;
    chk("c2_relv", int'(bus.release_valid), 3);
    chk("c2_phy0", int'(bus.release_phy[0]), 7);
    chk("c2_phy1", int'(bus.release_phy[1]), 50);

    // Non-writing slot must neither bypass nor release
    bus.commit_valid = 2'b11; bus.commit_write_reg = 2'b10;
    bus.commit_log_dst[0] = 5'd9; bus.commit_phy_dst[0] = 7'd99;
    bus.commit_log_dst[1] = 5'd9; bus.commit_phy_dst[1] = 7'd70;
    tick();
    clearCommit();
    expMap[9] = 70;
    chk("c3_relv", int'(bus.release_valid), 2);
    chk("c3_phy0", int'(bus.release_phy[0]), 0);
    chk("c3_phy1", int'(bus.release_phy[1]), 9);

    // 4: commit log3->p60 together with recovery_start; walk sees post-commit map
    bus.commit_valid = 2'b01; bus.commit_write_reg = 2'b01;
    bus.commit_log_dst[0] = 5'd3; bus.commit_phy_dst[0] = 7'd60;
    expMap[3] = 60;
    startWalk();
    clearCommit();
    chk("c4_relv", int'(bus.release_valid), 1);
    chk("c4_phy0", int'(bus.release_phy[0]), 3);
    checkBeats("walk2", 16);
    chk("walk2_done", int'(bus.recovery_done), 1);
    tick();

    // 5: restart at beat 6; no done until 16 further beats
    startWalk();
    checkBeats("walk3a", 6);
    chk("walk3_b6_log", int'(bus.rmt_wr_log[0]), 12);
    startWalk();
    checkBeats("walk3b", 16);
    chk("walk3_done", int'(bus.recovery_done), 1);
    tick();
    chk("walk3_done_pulse", int'(bus.recovery_done), 0);

    // 6: reset during beat 9 aborts walk and restores identity map
    startWalk();
    checkBeats("walk4", 9);
    chk("walk4_b9_log", int'(bus.rmt_wr_log[0]), 18);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < LREG_NUM; i++) expMap[i] = i;
    chkIdle("abort");
    chk("abort_done", int'(bus.recovery_done), 0);
    tick();
    chk("abort_done2", int'(bus.recovery_done), 0);
    startWalk();
    checkBeats("walk5", 16);
    chk("walk5_done", int'(bus.recovery_done), 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
